// File: rtl/fsm_cc8_pkg.sv
// Shared cc8 controller definitions: state encoding, drive bundle,
// expected outputs and the transition function used by shadows and monitors.
package fsm_cc8_pkg;

   localparam int unsigned ST_W = 4;

   typedef logic [ST_W-1:0] cc8_state_t;

   localparam cc8_state_t S0 = 4'd0;
   localparam cc8_state_t S1 = 4'd1;
   localparam cc8_state_t S2 = 4'd2;
   localparam cc8_state_t S3 = 4'd3;
   localparam cc8_state_t S4 = 4'd4;
   localparam cc8_state_t S5 = 4'd5;
   localparam cc8_state_t S6 = 4'd6;
   localparam cc8_state_t S7 = 4'd7;
   localparam cc8_state_t S8 = 4'd8;
   localparam cc8_state_t S9 = 4'd9;

   typedef struct packed {
      logic go;
      logic jmp;
      logic sk0;
      logic sk1;
   } cc8_drive_t;

   typedef enum logic [1:0] {
      DRV_IDLE = 2'd0,
      DRV_RUN  = 2'd1,
      DRV_ERR  = 2'd2
   } drv_state_e;

   // Controller outputs {y1,y2,y3} as a function of its state
   function automatic logic [2:0] cc8_exp_y(input cc8_state_t s);
      logic [2:0] y;
      case (s)
         S1:      y = 3'b010;
         S3:      y = 3'b110;
         S6:      y = 3'b111;
         S7:      y = 3'b001;
         S8:      y = 3'b011;
         S9:      y = 3'b111;
         default: y = 3'b000;
      endcase
      return y;
   endfunction

   // Next controller state; jmp overrides everything outside S0
   function automatic cc8_state_t cc8_next(input cc8_state_t s, input cc8_drive_t d);
      cc8_state_t n;
      n = S0;
      if (d.jmp && (s != S0)) begin
         n = S3;
      end else begin
         case (s)
            S0: n = !d.go ? S0 : (d.jmp ? S3 : S1);
            S1: n = S2;
            S2: n = S9;
            S3: n = S4;
            S4: n = d.sk0 ? S6 : S5;
            S5: begin
               case ({d.sk1, d.sk0})
                  2'b00:   n = S6;
                  2'b01:   n = S7;
                  2'b10:   n = S8;
                  default: n = S9;
               endcase
            end
            S6: n = d.go ? S7 : S6;
            S7: n = S8;
            S8: n = S9;
            default: n = S0;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/fsm_cc8_route.sv
// Routing policy: drive values that move the controller from state_i
// one hop closer to target_i.
module fsm_cc8_route
   import fsm_cc8_pkg::*;
(
   input  cc8_state_t state_i,
   input  cc8_state_t target_i,
   output cc8_drive_t drive_c_o
);

   always_comb begin
      drive_c_o = '0;
      if (state_i != target_i) begin
         if (target_i == S3) begin
            drive_c_o.jmp = 1'b1;
            drive_c_o.go  = (state_i == S0);
         end else begin
            case (state_i)
               S0: begin
                  drive_c_o.go  = 1'b1;
                  drive_c_o.jmp = !(target_i inside {S1, S2, S9});
               end
               S1: drive_c_o.jmp = !(target_i inside {S2, S9, S0});
               S2: drive_c_o.jmp = !(target_i inside {S9, S0, S1});
               S4: begin
                  if (target_i == S6) begin
                     drive_c_o.sk0 = 1'b1;
                  end else if (target_i == S4) begin
                     drive_c_o.jmp = 1'b1;
                  end
               end
               S5: begin
                  case (target_i)
                     S7:             drive_c_o.sk0 = 1'b1;
                     S8:             drive_c_o.sk1 = 1'b1;
                     S9, S0, S1, S2: begin
                        drive_c_o.sk1 = 1'b1;
                        drive_c_o.sk0 = 1'b1;
                     end
                     S4, S5:         drive_c_o.jmp = 1'b1;
                     default:        drive_c_o = '0;
                  endcase
               end
               S6: begin
                  if (target_i inside {S7, S8, S9, S0, S1, S2}) begin
                     drive_c_o.go = 1'b1;
                  end else begin
                     drive_c_o.jmp = 1'b1;
                  end
               end
               S7: drive_c_o.jmp = !(target_i inside {S8, S9, S0, S1, S2});
               S8: drive_c_o.jmp = !(target_i inside {S9, S0, S1, S2});
               S9: drive_c_o.jmp = !(target_i inside {S0, S1, S2});
               default: drive_c_o = '0;
            endcase
         end
      end
   end

endmodule

// File: rtl/fsm_cc8_drv.sv
// Command-driven initiator for one cc8 controller: steers it to a requested
// state, keeps a cycle-accurate shadow and checks its y outputs against it.
module fsm_cc8_drv
   import fsm_cc8_pkg::*;
#(
   parameter int unsigned MAX_HOPS = 8,
   parameter bit          CHECK_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_target,
   input  logic       y1,
   input  logic       y2,
   input  logic       y3,
   output logic       go,
   output logic       jmp,
   output logic       sk0,
   output logic       sk1,
   output logic       done,
   output logic       bad_cmd,
   output logic       err,
   output logic [3:0] shadow_state
);

   localparam int unsigned HOP_W = $clog2(MAX_HOPS + 1);

   drv_state_e state_q, state_d;
   cc8_state_t shadow_q, shadow_d;
   cc8_state_t target_q, target_d;
   logic [HOP_W-1:0] hop_q, hop_d, hop_inc;
   cc8_drive_t drive_q, drive_d, route_c;
   logic done_q, done_d;
   logic bad_q, bad_d;
   logic err_q, err_d;
   logic ready_q, ready_d;
   logic accept, y_mis, at_tgt, timeout;

   // Shadow and target of the next cycle feed the router
   always_comb begin
      accept   = (state_q == DRV_IDLE) && cmd_valid && (cmd_target <= S9);
      shadow_d = cc8_next(shadow_q, drive_q);
      target_d = accept ? cmd_target : target_q;
      y_mis    = CHECK_EN && ({y1, y2, y3} != cc8_exp_y(shadow_q));
   end

   fsm_cc8_route u_route (
      .state_i   (shadow_d),
      .target_i  (target_d),
      .drive_c_o (route_c)
   );

   always_comb begin
      state_d = state_q;
      hop_d   = hop_q;
      err_d   = err_q;
      bad_d   = 1'b0;
      hop_inc = hop_q + HOP_W'(1);
      at_tgt  = (shadow_q == target_q);
      timeout = !at_tgt && (hop_inc >= HOP_W'(MAX_HOPS));
      case (state_q)
         DRV_IDLE: begin
            if (accept) begin
               state_d = DRV_RUN;
               hop_d   = '0;
            end else if (cmd_valid) begin
               bad_d = 1'b1;
            end
         end
         DRV_RUN: begin
            hop_d = hop_inc;
            if (at_tgt) begin
               state_d = DRV_IDLE;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = DRV_ERR;
            end
         end
         default: state_d = DRV_ERR;
      endcase
      if (y_mis) begin
         err_d   = 1'b1;
         bad_d   = 1'b0;
         state_d = DRV_ERR;
      end
      // done lines up with the cycle in which the shadow sits on the target
      done_d  = (state_d == DRV_RUN) && (shadow_d == target_d);
      ready_d = (state_d == DRV_IDLE);
      drive_d = (state_d == DRV_RUN) ? route_c : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DRV_IDLE;
         shadow_q <= S0;
         target_q <= S0;
         hop_q    <= '0;
         drive_q  <= '0;
         done_q   <= 1'b0;
         bad_q    <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         target_q <= target_d;
         hop_q    <= hop_d;
         drive_q  <= drive_d;
         done_q   <= done_d;
         bad_q    <= bad_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   assign cmd_ready    = ready_q;
   assign go           = drive_q.go;
   assign jmp          = drive_q.jmp;
   assign sk0          = drive_q.sk0;
   assign sk1          = drive_q.sk1;
   assign done         = done_q;
   assign bad_cmd      = bad_q;
   assign err          = err_q;
   assign shadow_state = shadow_q;

endmodule

// File: tb/tb_fsm_cc8_drv.sv
// Bench for fsm_cc8_drv: a behavioural cc8 controller closes the loop,
// directed vectors cover the main routes, then error and all-pairs sequences.
module tb_fsm_cc8_drv;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_target;
   logic       y1, y2, y3;
   logic       go, jmp, sk0, sk1;
   logic       done, bad_cmd, err;
   logic [3:0] shadow_state;

   int total = 0;
   int bad   = 0;

   logic [3:0] ctrl_q;
   logic       force_y;

   fsm_cc8_drv #(.MAX_HOPS(8), .CHECK_EN(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_target   (cmd_target),
      .y1           (y1),
      .y2           (y2),
      .y3           (y3),
      .go           (go),
      .jmp          (jmp),
      .sk0          (sk0),
      .sk1          (sk1),
      .done         (done),
      .bad_cmd      (bad_cmd),
      .err          (err),
      .shadow_state (shadow_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference cc8 controller
   function automatic logic [3:0] ctrl_next(input logic [3:0] s, input logic g, input logic j,
                                            input logic k0, input logic k1);
      if (s == 4'd0) return g ? (j ? 4'd3 : 4'd1) : 4'd0;
      if (j) return 4'd3;
      case (s)
         4'd1: return 4'd2;
         4'd2: return 4'd9;
         4'd3: return 4'd4;
         4'd4: return k0 ? 4'd6 : 4'd5;
         4'd5: return 4'd6 + 4'({k1, k0});
         4'd6: return g ? 4'd7 : 4'd6;
         4'd7: return 4'd8;
         4'd8: return 4'd9;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [2:0] ctrl_y(input logic [3:0] s);
      case (s)
         4'd1: return 3'b010;
         4'd3: return 3'b110;
         4'd6: return 3'b111;
         4'd7: return 3'b001;
         4'd8: return 3'b011;
         4'd9: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) ctrl_q <= 4'd0;
      else     ctrl_q <= ctrl_next(ctrl_q, go, jmp, sk0, sk1);
   end

   assign {y1, y2, y3} = force_y ? 3'b000 : ctrl_y(ctrl_q);

   typedef struct {
      logic        rst;
      logic        vld;
      logic [3:0]  tgt;
      logic [11:0] exp;   // {go,jmp,sk0,sk1, done, bad_cmd, err, cmd_ready, shadow[3:0]}
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mk(input logic r, input logic v, input logic [3:0] t,
                               input logic [3:0] drv, input logic d, input logic b,
                               input logic e, input logic rd, input logic [3:0] sh);
      vec_t x;
      x.rst = r;
      x.vld = v;
      x.tgt = t;
      x.exp = {drv, d, b, e, rd, sh};
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
      total++;
      if (got !== need) begin
         bad++;
         $display("FAIL %s: got %0h need %0h", name, got, need);
      end
   endtask

   task automatic send(input logic [3:0] t);
      int k;
      k = 0;
      while (!cmd_ready && k < 10) begin
         step();
         k++;
      end
      cmd_valid  = 1'b1;
      cmd_target = t;
      step();
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_done(output int n, output logic seen);
      n = 1;
      while (!done && n < 12) begin
         step();
         n++;
      end
      seen = done;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int   n;
      logic seen;

      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_target = 4'd0;
      force_y    = 1'b0;
      step();

      vecs[0]  = mk(1, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd0);
      vecs[1]  = mk(0, 1, 4'd8,  4'b1100, 0, 0, 0, 0, 4'd0);
      vecs[2]  = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 0, 4'd3);
      vecs[3]  = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 0, 4'd4);
      vecs[4]  = mk(0, 0, 4'd0,  4'b0001, 0, 0, 0, 0, 4'd5);
      vecs[5]  = mk(0, 0, 4'd0,  4'b0000, 1, 0, 0, 0, 4'd8);
      vecs[6]  = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd9);
      vecs[7]  = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd0);
      vecs[8]  = mk(0, 1, 4'd2,  4'b1000, 0, 0, 0, 0, 4'd0);
      vecs[9]  = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 0, 4'd1);
      vecs[10] = mk(0, 0, 4'd0,  4'b0000, 1, 0, 0, 0, 4'd2);
      vecs[11] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd9);
      vecs[12] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd0);
      vecs[13] = mk(0, 1, 4'd12, 4'b0000, 0, 1, 0, 1, 4'd0);
      vecs[14] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd0);
      vecs[15] = mk(0, 1, 4'd0,  4'b0000, 1, 0, 0, 0, 4'd0);
      vecs[16] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd0);
      vecs[17] = mk(0, 1, 4'd6,  4'b1100, 0, 0, 0, 0, 4'd0);
      vecs[18] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 0, 4'd3);
      vecs[19] = mk(0, 0, 4'd0,  4'b0010, 0, 0, 0, 0, 4'd4);
      vecs[20] = mk(0, 0, 4'd0,  4'b0000, 1, 0, 0, 0, 4'd6);
      vecs[21] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd6);
      vecs[22] = mk(0, 1, 4'd4,  4'b0100, 0, 0, 0, 0, 4'd6);
      vecs[23] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 0, 4'd3);
      vecs[24] = mk(0, 0, 4'd0,  4'b0000, 1, 0, 0, 0, 4'd4);
      vecs[25] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd5);
      vecs[26] = mk(0, 0, 4'd0,  4'b0000, 0, 0, 0, 1, 4'd6);

      for (int i = 0; i < 27; i++) begin
         rst        = vecs[i].rst;
         cmd_valid  = vecs[i].vld;
         cmd_target = vecs[i].tgt;
         step();
         cmd_valid  = 1'b0;
         check($sformatf("vec%0d", i),
               32'({go, jmp, sk0, sk1, done, bad_cmd, err, cmd_ready, shadow_state}),
               32'(vecs[i].exp));
      end

      // y mismatch while the shadow is in S3, then sticky err until reset
      send(4'd3);
      n = 0;
      while (shadow_state != 4'd3 && n < 8) begin
         step();
         n++;
      end
      check("reach_s3", 32'(shadow_state), 32'd3);
      force_y = 1'b1;
      step();
      force_y = 1'b0;
      check("err_set", 32'({err, cmd_ready}), 32'b10);
      cmd_valid  = 1'b1;
      cmd_target = 4'd2;
      step();
      cmd_valid  = 1'b0;
      step();
      step();
      check("err_hold", 32'({err, cmd_ready, go, jmp, sk0, sk1}), 32'b100000);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_clear", 32'({err, cmd_ready, shadow_state}), 32'({2'b01, 4'd0}));

      // All start/target pairs routed through the reference controller
      for (int a = 0; a < 10; a++) begin
         for (int t = 0; t < 10; t++) begin
            send(4'(a));
            wait_done(n, seen);
            send(4'(t));
            wait_done(n, seen);
            check($sformatf("pair%0d_%0d_cycles%0d", a, t, n),
                  32'({seen, (n <= 7), shadow_state, ctrl_q, err}),
                  32'({1'b1, 1'b1, 4'(t), 4'(t), 1'b0}));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
